// File: rtl/score_leaderboard_pkg.sv
// Shared types and helpers for the score leaderboard: FSM states, the
// no-player ID, the BCD digit check and rank/counter width sizing.
package score_leaderboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSERT = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_SEND   = 2'd3
  } state_t;

  // Internal ID reserved for "no player"; never ranked
  localparam int unsigned NO_PLAYER = 0;
  localparam int unsigned BCD_MAX   = 9;

  // True when a 4-bit nibble is a legal BCD digit
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'(BCD_MAX);
  endfunction

  // Index width for n items, never less than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/score_rank_insert.sv
// Combinational sorted insert: given the current table and a candidate
// entry, decide whether and where it lands and produce the next table.
module score_rank_insert
  import score_leaderboard_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned INT_ID_W    = 3,
  parameter int unsigned DIGITS      = 2
) (
  input  logic [NUM_ENTRIES-1:0]                  valid,
  input  logic [NUM_ENTRIES-1:0][4*DIGITS-1:0]    score,
  input  logic [NUM_ENTRIES-1:0][INT_ID_W-1:0]    id,
  input  logic                                    new_is_guest,
  input  logic [INT_ID_W-1:0]                     new_id,
  input  logic [4*DIGITS-1:0]                     new_score,
  output logic                                    ins_en,
  output logic [NUM_ENTRIES-1:0]                  nxt_valid,
  output logic [NUM_ENTRIES-1:0][4*DIGITS-1:0]    nxt_score,
  output logic [NUM_ENTRIES-1:0][INT_ID_W-1:0]    nxt_id
);

  localparam int unsigned RK_W = idx_w(NUM_ENTRIES);

  logic            eligible;
  logic            found;
  logic [RK_W-1:0] pos;

  // Guests, the no-player ID and malformed BCD are never ranked
  always_comb begin
    eligible = !new_is_guest && (new_id != INT_ID_W'(NO_PLAYER));
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (!digit_ok(new_score[4*d +: 4])) eligible = 1'b0;
    end
  end

  // Highest rank whose slot is empty or not above the new score (ties go above)
  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid[i] || (new_score >= score[i])) begin
        found = 1'b1;
        pos   = RK_W'(i);
      end
    end
  end

  assign ins_en = eligible && found;

  // Entries below the insert point slide down one rank; the last one falls off
  always_comb begin
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      int unsigned up;
      up           = (i > 0) ? i - 1 : 0;
      nxt_valid[i] = valid[i];
      nxt_score[i] = score[i];
      nxt_id[i]    = id[i];
      if (ins_en) begin
        if (i == int'(pos)) begin
          nxt_valid[i] = 1'b1;
          nxt_score[i] = new_score;
          nxt_id[i]    = new_id;
        end else if (i > int'(pos)) begin
          nxt_valid[i] = valid[up];
          nxt_score[i] = score[up];
          nxt_id[i]    = id[up];
        end
      end
    end
  end

endmodule

// File: rtl/score_leaderboard.sv
// Sorted top-N leaderboard of (BCD score, internal ID). Accepts score
// submissions and serves rank reads, fetching the external ID from the
// player-ID store over a fixed-latency lookup port.
module score_leaderboard
  import score_leaderboard_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned INT_ID_W    = 3,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned EXT_ID_W    = 16,
  parameter int unsigned LOOKUP_WAIT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             sub_valid,
  input  logic                             sub_is_guest,
  input  logic [INT_ID_W-1:0]              sub_int_id,
  input  logic [4*DIGITS-1:0]              sub_score,
  output logic                             sub_ack,
  input  logic                             rd_req,
  input  logic [idx_w(NUM_ENTRIES)-1:0]    rd_rank,
  output logic [INT_ID_W-1:0]              lookup_id,
  input  logic [EXT_ID_W-1:0]              lookup_data,
  output logic                             rd_valid,
  output logic [4*DIGITS-1:0]              rd_score,
  output logic [EXT_ID_W-1:0]              rd_ext_id,
  output logic                             busy
);

  localparam int unsigned SC_W    = 4 * DIGITS;
  localparam int unsigned RK_W    = idx_w(NUM_ENTRIES);
  localparam int unsigned RK_SPAN = 1 << RK_W;
  localparam int unsigned CNT_W   = idx_w(LOOKUP_WAIT);

  state_t                             state;
  logic [NUM_ENTRIES-1:0]             valid_q;
  logic [NUM_ENTRIES-1:0][SC_W-1:0]   score_q;
  logic [NUM_ENTRIES-1:0][INT_ID_W-1:0] id_q;

  logic                               new_guest_q;
  logic [INT_ID_W-1:0]                new_id_q;
  logic [SC_W-1:0]                    new_score_q;

  logic [RK_W-1:0]                    rank_q;
  logic [CNT_W-1:0]                   cnt_q;

  logic                               ins_en;
  logic [NUM_ENTRIES-1:0]             nxt_valid;
  logic [NUM_ENTRIES-1:0][SC_W-1:0]   nxt_score;
  logic [NUM_ENTRIES-1:0][INT_ID_W-1:0] nxt_id;

  // Valid bits padded to the full rank range so out-of-range ranks read as empty
  logic [RK_SPAN-1:0]                 valid_span;
  logic                               rank_ok;

  assign valid_span = RK_SPAN'(valid_q);
  assign rank_ok    = valid_span[rd_rank];

  score_rank_insert #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .INT_ID_W    (INT_ID_W),
    .DIGITS      (DIGITS)
  ) u_insert (
    .valid        (valid_q),
    .score        (score_q),
    .id           (id_q),
    .new_is_guest (new_guest_q),
    .new_id       (new_id_q),
    .new_score    (new_score_q),
    .ins_en       (ins_en),
    .nxt_valid    (nxt_valid),
    .nxt_score    (nxt_score),
    .nxt_id       (nxt_id)
  );

  // Control FSM, table registers, lookup counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      valid_q     <= '0;
      score_q     <= '0;
      id_q        <= '0;
      new_guest_q <= 1'b0;
      new_id_q    <= '0;
      new_score_q <= '0;
      rank_q      <= '0;
      cnt_q       <= '0;
      sub_ack     <= 1'b0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      lookup_id   <= '0;
      rd_score    <= '0;
      rd_ext_id   <= '0;
    end else begin
      sub_ack  <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clear) begin
            valid_q <= '0;
          end else if (sub_valid) begin
            new_guest_q <= sub_is_guest;
            new_id_q    <= sub_int_id;
            new_score_q <= sub_score;
            sub_ack     <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_INSERT;
          end else if (rd_req) begin
            busy <= 1'b1;
            if (rank_ok) begin
              lookup_id <= id_q[rd_rank];
              rank_q    <= rd_rank;
              cnt_q     <= '0;
              state     <= ST_LOOKUP;
            end else begin
              rd_score  <= '0;
              rd_ext_id <= '0;
              rd_valid  <= 1'b1;
              state     <= ST_SEND;
            end
          end
        end
        ST_INSERT: begin
          if (ins_en) begin
            valid_q <= nxt_valid;
            score_q <= nxt_score;
            id_q    <= nxt_id;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_LOOKUP: begin
          if (cnt_q == CNT_W'(LOOKUP_WAIT - 1)) begin
            rd_ext_id <= lookup_data;
            rd_score  <= score_q[rank_q];
            rd_valid  <= 1'b1;
            state     <= ST_SEND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SEND: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_leaderboard.sv
// Directed bench for score_leaderboard with a queue-based leaderboard model,
// a per-cycle compare process for sub_ack / rd_valid / read data, and
// hand-computed literal expectations for the documented scenarios.
module tb_score_leaderboard;

  localparam int N   = 4;
  localparam int IW  = 3;
  localparam int DG  = 2;
  localparam int SCW = 8;
  localparam int EW  = 16;
  localparam int LW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clear = 1'b0;
  logic           sub_valid = 1'b0;
  logic           sub_is_guest = 1'b0;
  logic [IW-1:0]  sub_int_id = '0;
  logic [SCW-1:0] sub_score = '0;
  logic           sub_ack;
  logic           rd_req = 1'b0;
  logic [1:0]     rd_rank = '0;
  logic [IW-1:0]  lookup_id;
  logic [EW-1:0]  lookup_data;
  logic           rd_valid;
  logic [SCW-1:0] rd_score;
  logic [EW-1:0]  rd_ext_id;
  logic           busy;

  always #5 clk = ~clk;

  score_leaderboard #(
    .NUM_ENTRIES (N),
    .INT_ID_W    (IW),
    .DIGITS      (DG),
    .EXT_ID_W    (EW),
    .LOOKUP_WAIT (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sub_valid    (sub_valid),
    .sub_is_guest (sub_is_guest),
    .sub_int_id   (sub_int_id),
    .sub_score    (sub_score),
    .sub_ack      (sub_ack),
    .rd_req       (rd_req),
    .rd_rank      (rd_rank),
    .lookup_id    (lookup_id),
    .lookup_data  (lookup_data),
    .rd_valid     (rd_valid),
    .rd_score     (rd_score),
    .rd_ext_id    (rd_ext_id),
    .busy         (busy)
  );

  // Player-ID store
  logic [EW-1:0] ext_mem [8];
  assign lookup_data = ext_mem[lookup_id];

  // Leaderboard model: descending list, newest first among equals
  typedef struct { logic [SCW-1:0] sc; logic [IW-1:0] id; } ent_t;
  ent_t tab[$];

  typedef struct { int cyc; logic [SCW-1:0] sc; logic [EW-1:0] ext; } rexp_t;
  rexp_t rq[$];

  int cyc = 0;
  int exp_ack = -1;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic void model_insert(input logic g, input logic [IW-1:0] id,
                                       input logic [SCW-1:0] sc);
    int p;
    ent_t e;
    if (g || id == '0) return;
    for (int d = 0; d < DG; d++) if (sc[4*d +: 4] > 4'd9) return;
    p = 0;
    foreach (tab[i]) if (tab[i].sc > sc) p++;
    e.sc = sc;
    e.id = id;
    tab.insert(p, e);
    if (tab.size() > N) void'(tab.pop_back());
  endfunction

  function automatic void push_read_exp(input int rank, input int t);
    rexp_t r;
    if (rank < tab.size()) begin
      r.cyc = t + LW + 1;
      r.sc  = tab[rank].sc;
      r.ext = ext_mem[tab[rank].id];
    end else begin
      r.cyc = t + 1;
      r.sc  = '0;
      r.ext = '0;
    end
    rq.push_back(r);
  endfunction

  // Per-cycle comparison of handshake pulses and read data
  always @(negedge clk) begin
    if (rst) begin
      chk("sub_ack", 32'(sub_ack), 32'(cyc == exp_ack));
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_score", 32'(rd_score), 32'(rq[0].sc));
        chk("rd_ext_id", 32'(rd_ext_id), 32'(rq[0].ext));
        void'(rq.pop_front());
      end else begin
        chk("rd_valid_quiet", 32'(rd_valid), 32'd0);
      end
    end
  end

  task automatic wait_ack();
    int n;
    n = 0;
    while (!sub_ack && n < 20) begin @(negedge clk); n++; end
    if (!sub_ack) timeout("sub_ack_wait");
  endtask

  task automatic wait_rd();
    int n;
    n = 0;
    while (!rd_valid && n < 20) begin @(negedge clk); n++; end
    if (!rd_valid) timeout("rd_valid_wait");
  endtask

  task automatic submit(input logic g, input logic [IW-1:0] id, input logic [SCW-1:0] sc);
    @(negedge clk);
    exp_ack      = cyc + 1;
    sub_valid    = 1'b1;
    sub_is_guest = g;
    sub_int_id   = id;
    sub_score    = sc;
    @(negedge clk);
    wait_ack();
    chk("busy_insert", 32'(busy), 32'd1);
    sub_valid = 1'b0;
    model_insert(g, id, sc);
    @(negedge clk);
    chk("busy_after_insert", 32'(busy), 32'd0);
  endtask

  task automatic read(input int rank);
    int t;
    @(negedge clk);
    t = cyc;
    push_read_exp(rank, t);
    rd_rank = 2'(rank);
    rd_req  = 1'b1;
    @(negedge clk);
    if (rank < tab.size()) begin
      chk("lookup_id", 32'(lookup_id), 32'(tab[rank].id));
      chk("busy_lookup", 32'(busy), 32'd1);
    end
    wait_rd();
    rd_req = 1'b0;
    @(negedge clk);
    chk("busy_after_read", 32'(busy), 32'd0);
  endtask

  task automatic read_lit(input int rank, input logic [SCW-1:0] sc, input logic [EW-1:0] ext);
    read(rank);
    chk("lit_score", 32'(rd_score), 32'(sc));
    chk("lit_ext_id", 32'(rd_ext_id), 32'(ext));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("busy_clear", 32'(busy), 32'd0);
    tab.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 8; i++) ext_mem[i] = 16'h1000 + 16'(i);
    ext_mem[2] = 16'hBEEF;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sub_ack", 32'(sub_ack), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_lookup_id", 32'(lookup_id), 32'd0);
    chk("rst_rd_score", 32'(rd_score), 32'd0);
    chk("rst_rd_ext_id", 32'(rd_ext_id), 32'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Empty table read: immediate zero reply
    read_lit(0, 8'h00, 16'h0000);

    // Fill, tie ordering and eviction
    submit(1'b0, 3'd1, 8'h45);
    submit(1'b0, 3'd2, 8'h72);
    submit(1'b0, 3'd3, 8'h45);
    submit(1'b0, 3'd4, 8'h10);
    submit(1'b0, 3'd5, 8'h50);
    read_lit(1, 8'h50, 16'h1005);
    read_lit(2, 8'h45, 16'h1003);
    read_lit(3, 8'h45, 16'h1001);
    read_lit(0, 8'h72, 16'hBEEF);
    chk("lit_lookup_id_rank0", 32'(lookup_id), 32'd2);

    // Rejected submissions leave the table alone
    submit(1'b1, 3'd6, 8'h99);
    submit(1'b0, 3'd6, 8'h9A);
    submit(1'b0, 3'd6, 8'hA1);
    submit(1'b0, 3'd0, 8'h99);
    submit(1'b0, 3'd6, 8'h20);
    read_lit(0, 8'h72, 16'hBEEF);
    read_lit(3, 8'h45, 16'h1001);

    // Tie with the bottom pair of a full table
    submit(1'b0, 3'd7, 8'h45);
    read_lit(2, 8'h45, 16'h1007);
    read_lit(3, 8'h45, 16'h1003);

    // Simultaneous submit and read: insert first, read sees new rank 0
    @(negedge clk);
    t            = cyc;
    exp_ack      = t + 1;
    sub_valid    = 1'b1;
    sub_is_guest = 1'b0;
    sub_int_id   = 3'd4;
    sub_score    = 8'h80;
    rd_rank      = 2'd0;
    rd_req       = 1'b1;
    @(negedge clk);
    wait_ack();
    sub_valid = 1'b0;
    model_insert(1'b0, 3'd4, 8'h80);
    push_read_exp(0, t + 2);
    wait_rd();
    rd_req = 1'b0;
    chk("lit_both_score", 32'(rd_score), 32'h80);
    chk("lit_both_ext_id", 32'(rd_ext_id), 32'h1004);
    @(negedge clk);
    chk("busy_after_both", 32'(busy), 32'd0);

    // Clear wipes the table
    do_clear();
    read_lit(0, 8'h00, 16'h0000);
    read_lit(3, 8'h00, 16'h0000);

    // Reset during a lookup aborts at once
    submit(1'b0, 3'd2, 8'h33);
    @(negedge clk);
    rd_rank = 2'd0;
    rd_req  = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_pre_abort", 32'(busy), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_lookup_id", 32'(lookup_id), 32'd0);
    rd_req = 1'b0;
    tab.delete();
    @(posedge clk); #2 rst = 1'b1;
    read_lit(0, 8'h00, 16'h0000);
    read_lit(1, 8'h00, 16'h0000);

    repeat (3) @(negedge clk);
    if (rq.size() != 0) timeout("pending_reads");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
